// File: rtl/mic1_pkg.sv
// Shared constants and types for the MIC-1 post-ALU shifter stage.
package mic1_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int C_WIDTH    = 9;

  localparam logic [1:0] SH_NONE    = 2'b00;
  localparam logic [1:0] SH_SRA1    = 2'b01;
  localparam logic [1:0] SH_SLL8    = 2'b10;
  localparam logic [1:0] SH_ILLEGAL = 2'b11;

  // Bit positions of the C-bus destination mask
  localparam int C_H   = 0;
  localparam int C_OPC = 1;
  localparam int C_TOS = 2;
  localparam int C_CPP = 3;
  localparam int C_LV  = 4;
  localparam int C_SP  = 5;
  localparam int C_PC  = 6;
  localparam int C_MDR = 7;
  localparam int C_MAR = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/mic1_shifter.sv
// MIC-1 shifter: pass, SLL8 or SRA1; code 11 passes the word and flags it.
module mic1_shifter
  import mic1_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic [W-1:0] data_in,
  input  logic [1:0]   shift,
  output logic [W-1:0] data_out,
  output logic         illegal
);

  always_comb begin
    data_out = data_in;
    illegal  = 1'b0;
    case (shift)
      SH_SLL8:    data_out = data_in << 8;
      SH_SRA1:    data_out = {data_in[W-1], data_in[W-1:1]};
      SH_ILLEGAL: illegal  = 1'b1;
      default:    data_out = data_in;
    endcase
  end

endmodule

// File: rtl/mic1_shifter_stage.sv
// Post-ALU stage: shift at input, 2-entry elastic buffer to C-bus write-back,
// N/Z flip-flops loaded when an entry retires.
//
// state | meaning
// EMPTY | no entry buffered, out_valid = 0
// ONE   | head entry valid, room for one more
// TWO   | head and tail valid, in_ready = 0
module mic1_shifter_stage
  import mic1_pkg::*;
#(
  parameter int DATA_WIDTH = mic1_pkg::DATA_WIDTH,
  parameter int C_WIDTH    = mic1_pkg::C_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_n,
  input  logic                  alu_z,
  input  logic [1:0]            shift,
  input  logic [C_WIDTH-1:0]    c_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] c_bus,
  output logic [C_WIDTH-1:0]    c_en,
  output logic                  n_flag,
  output logic                  z_flag,
  output logic                  shift_err
);

  buf_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] head_data_q, tail_data_q, shifted;
  logic [C_WIDTH-1:0]    head_sel_q, tail_sel_q;
  logic                  head_n_q, head_z_q, tail_n_q, tail_z_q;
  logic                  out_valid_q, n_q, z_q, err_q;
  logic                  illegal, push, pop;
  logic                  load_head_new, load_head_tail, load_tail;

  mic1_shifter #(.W(DATA_WIDTH)) u_shifter (
    .data_in  (alu_out),
    .shift    (shift),
    .data_out (shifted),
    .illegal  (illegal)
  );

  assign push = in_valid && in_ready;
  assign pop  = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE:     if (push && !pop) state_d = TWO;
               else if (pop && !push) state_d = EMPTY;
      TWO:     if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != TWO) && !reset;
    out_valid = out_valid_q;
    c_bus     = head_data_q;
    c_en      = head_sel_q & {C_WIDTH{out_valid_q}};
    n_flag    = n_q;
    z_flag    = z_q;
    shift_err = err_q;
  end

  // A push that coincides with the last pop goes straight to the head slot
  assign load_head_new  = push && ((state_q == EMPTY) || ((state_q == ONE) && pop));
  assign load_tail      = push && (state_q == ONE) && !pop;
  assign load_head_tail = pop && (state_q == TWO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_data_q <= '0;
      head_sel_q  <= '0;
      head_n_q    <= 1'b0;
      head_z_q    <= 1'b0;
      tail_data_q <= '0;
      tail_sel_q  <= '0;
      tail_n_q    <= 1'b0;
      tail_z_q    <= 1'b0;
      out_valid_q <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (load_head_new) begin
        head_data_q <= shifted;
        head_sel_q  <= c_sel;
        head_n_q    <= alu_n;
        head_z_q    <= alu_z;
      end else if (load_head_tail) begin
        head_data_q <= tail_data_q;
        head_sel_q  <= tail_sel_q;
        head_n_q    <= tail_n_q;
        head_z_q    <= tail_z_q;
      end
      if (load_tail) begin
        tail_data_q <= shifted;
        tail_sel_q  <= c_sel;
        tail_n_q    <= alu_n;
        tail_z_q    <= alu_z;
      end
      if (pop) begin
        n_q <= head_n_q;
        z_q <= head_z_q;
      end
      if (push && illegal) err_q <= 1'b1;
      out_valid_q <= (state_d != EMPTY);
    end
  end

endmodule

// File: tb/tb_mic1_shifter_stage.sv
// Bench for mic1_shifter_stage: directed cases plus random traffic against a queue model.
module tb_mic1_shifter_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, alu_n, alu_z, out_valid, out_ready;
  logic [31:0] alu_out, c_bus;
  logic [1:0]  shift;
  logic [8:0]  c_sel, c_en;
  logic        n_flag, z_flag, shift_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic [8:0]  sel;
    logic        n;
    logic        z;
  } ent_t;

  ent_t mq[$];
  logic mn, mz, merr;

  mic1_shifter_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .shift     (shift),
    .c_sel     (c_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_bus     (c_bus),
    .c_en      (c_en),
    .n_flag    (n_flag),
    .z_flag    (z_flag),
    .shift_err (shift_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [1:0] sh);
    case (sh)
      2'b10:   return a * 32'd256;
      2'b01:   return (a / 32'd2) + (a[31] ? 32'h8000_0000 : 32'h0);
      default: return a;
    endcase
  endfunction

  task automatic drive(input bit v, input logic [31:0] d, input logic [1:0] sh,
                       input logic [8:0] cs, input bit n, input bit z, input bit ordy);
    in_valid  = v;
    alu_out   = d;
    shift     = sh;
    c_sel     = cs;
    alu_n     = n;
    alu_z     = z;
    out_ready = ordy;
  endtask

  // Check outputs mid-cycle against the model, then advance one clock
  task automatic step();
    bit   push, pop;
    ent_t e;
    @(negedge clk);
    chk("in_ready", in_ready, (mq.size() < 2) && !reset);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("c_bus", c_bus, mq[0].data);
      chk("c_en", c_en, mq[0].sel);
    end else begin
      chk("c_en_empty", c_en, 0);
    end
    chk("n_flag", n_flag, mn);
    chk("z_flag", z_flag, mz);
    chk("shift_err", shift_err, merr);
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() != 0);
    e.data = ref_shift(alu_out, shift);
    e.sel  = c_sel;
    e.n    = alu_n;
    e.z    = alu_z;
    @(posedge clk);
    if (pop) begin
      mn = mq[0].n;
      mz = mq[0].z;
      void'(mq.pop_front());
    end
    if (push) begin
      mq.push_back(e);
      if (shift == 2'b11) merr = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input bit ordy);
    drive(0, 32'h0, 2'b00, 9'h0, 0, 0, ordy);
  endtask

  initial begin
    reset = 1'b1;
    mn = 0; mz = 0; merr = 0;
    idle(1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c_bus", c_bus, 0);
    chk("rst_c_en", c_en, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_flags", {n_flag, z_flag, shift_err}, 0);
    reset = 1'b0;

    // pass-through
    drive(1, 32'h3, 2'b00, 9'h001, 0, 0, 1); step();
    chk("pass_c_bus", c_bus, 32'h3);
    chk("pass_c_en", c_en, 9'h001);
    idle(1); step();
    chk("pass_nz", {n_flag, z_flag}, 2'b00);

    drive(1, 32'hFF, 2'b10, 9'h004, 0, 0, 1); step();
    chk("sll8", c_bus, 32'h0000_FF00);
    idle(1); step();

    drive(1, 32'h8000_0004, 2'b01, 9'h002, 1, 0, 1); step();
    chk("sra1", c_bus, 32'hC000_0002);
    idle(1); step();
    chk("sra1_n", n_flag, 1);

    drive(1, 32'h0, 2'b00, 9'h001, 0, 1, 1); step();
    idle(1); step();
    chk("zero_z", z_flag, 1);

    // backpressure: 1,2 absorbed, 3 held until space frees
    drive(1, 32'h1, 2'b00, 9'h010, 0, 0, 0); step();
    alu_out = 32'h2; step();
    chk("bp_full", in_ready, 0);
    alu_out = 32'h3; step();
    out_ready = 1'b1; step();
    chk("bp_head2", c_bus, 32'h2);
    step();
    chk("bp_head3", c_bus, 32'h3);
    in_valid = 1'b0; step();
    step();

    // streaming with simultaneous push/pop
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h10 + i, 2'b00, 9'h020, 0, 0, 1); step();
      chk("stream_word", c_bus, 32'h10 + i);
      chk("stream_ready", in_ready, 1);
    end
    idle(1); step();

    drive(1, 32'h1234, 2'b11, 9'h040, 0, 0, 1); step();
    chk("illegal_pass", c_bus, 32'h1234);
    chk("illegal_err", shift_err, 1);
    drive(1, 32'h5, 2'b00, 9'h040, 0, 0, 1); step();
    idle(1); step();
    chk("err_sticky", shift_err, 1);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
            9'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3) != 0);
      step();
    end

    // fill to TWO, then reset between edges
    idle(1); step();
    drive(1, 32'hAAAA_0001, 2'b11, 9'h1FF, 1, 1, 0); step();
    alu_out = 32'hAAAA_0002; step();
    idle(0);
    chk("pre_rst_full", in_ready, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_c_en", c_en, 0);
    chk("arst_c_bus", c_bus, 0);
    chk("arst_flags", {n_flag, z_flag, shift_err}, 0);
    chk("arst_in_ready", in_ready, 0);
    mq.delete();
    mn = 0; mz = 0; merr = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1); step();
    chk("post_rst_empty", out_valid, 0);
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(0, 1), $urandom, 2'($urandom_range(0, 2)), 9'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
